// File: rtl/fft_peak_if.sv
// FFT output stream plus peak-result handshake for fft_peak_detect.
// Both directions sit in one bundle. The slave modport is the detector's view of it.
`timescale 1ns/1ps
interface fft_peak_if #(
    parameter int unsigned IDX_W = 10
);
    logic                    data_valid;
    logic signed [31:0]      data_re;
    logic signed [31:0]      data_im;
    logic                    peak_valid;
    logic                    peak_ready;
    logic [IDX_W-1:0]        peak_index;
    logic [32:0]             peak_mag;
    logic                    overrun;

    modport master (
        output data_valid, data_re, data_im, peak_ready,
        input  peak_valid, peak_index, peak_mag, overrun
    );

    modport slave (
        input  data_valid, data_re, data_im, peak_ready,
        output peak_valid, peak_index, peak_mag, overrun
    );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame L1-magnitude peak search on the FFT output stream, with a valid/ready result port.
// Optional macro FFT_PEAK_SKIP_DC_EN removes bin 0 from the search.
`timescale 1ns/1ps
module fft_peak_detect #(
    parameter int unsigned FRAME_LEN   = 1024,
    parameter int unsigned IDX_W       = 10,
    parameter bit          SEARCH_HALF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    fft_peak_if.slave   bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAG_W  = 33;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 load_c;
    logic                 frame_busy_c;

    logic [IDX_W-1:0]     bin_cnt;
    logic [DATA_W-1:0]    re_u, im_u, abs_re_c, abs_im_c;

    logic                 s1_valid, s1_last;
    logic [IDX_W-1:0]     s1_idx;
    logic [DATA_W-1:0]    s1_abs_re, s1_abs_im;

    logic                 s2_valid, s2_last;
    logic [IDX_W-1:0]     s2_idx;
    logic [MAG_W-1:0]     s2_mag;

    logic                 in_range_c;
    logic [MAG_W-1:0]     run_max, nxt_max_c, fin_max;
    logic [IDX_W-1:0]     run_idx, nxt_idx_c, fin_idx;
    logic                 cmp_last;

    logic                 peak_valid_q, overrun_q;
    logic [IDX_W-1:0]     peak_index_q;
    logic [MAG_W-1:0]     peak_mag_q;

    // Bin index is derived purely from the beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt <= '0;
        end else if (bus.data_valid) begin
            bin_cnt <= (bin_cnt == LAST_IDX) ? '0 : bin_cnt + IDX_W'(1);
        end
    end

    // Two's-complement abs; -2^31 maps to 2^31 as an unsigned value.
    assign re_u     = bus.data_re;
    assign im_u     = bus.data_im;
    assign abs_re_c = re_u[DATA_W-1] ? (~re_u + DATA_W'(1)) : re_u;
    assign abs_im_c = im_u[DATA_W-1] ? (~im_u + DATA_W'(1)) : im_u;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_idx    <= '0;
            s1_abs_re <= '0;
            s1_abs_im <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_idx    <= '0;
            s2_mag    <= '0;
        end else begin
            s1_valid  <= bus.data_valid;
            s1_last   <= bus.data_valid && (bin_cnt == LAST_IDX);
            s1_idx    <= bin_cnt;
            s1_abs_re <= abs_re_c;
            s1_abs_im <= abs_im_c;
            s2_valid  <= s1_valid;
            s2_last   <= s1_valid && s1_last;
            s2_idx    <= s1_idx;
            s2_mag    <= MAG_W'(s1_abs_re) + MAG_W'(s1_abs_im);
        end
    end

    // Running maximum; bin 0 restarts the search, strict compare keeps the lowest index on ties.
    always_comb begin
        in_range_c = 1'b1;
        if (SEARCH_HALF) begin
            in_range_c = ~s2_idx[IDX_W-1];
        end
        nxt_max_c = run_max;
        nxt_idx_c = run_idx;
        if (s2_valid) begin
            if (s2_idx == '0) begin
`ifdef FFT_PEAK_SKIP_DC_EN
                nxt_max_c = '0;
                nxt_idx_c = IDX_W'(1);
`else
                nxt_max_c = s2_mag;
                nxt_idx_c = '0;
`endif
            end else if (in_range_c && (s2_mag > run_max)) begin
                nxt_max_c = s2_mag;
                nxt_idx_c = s2_idx;
            end
        end
    end

    // The final result is snapshotted so a back-to-back next frame cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max  <= '0;
            run_idx  <= '0;
            fin_max  <= '0;
            fin_idx  <= '0;
            cmp_last <= 1'b0;
        end else begin
            run_max  <= nxt_max_c;
            run_idx  <= nxt_idx_c;
            cmp_last <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                fin_max <= nxt_max_c;
                fin_idx <= nxt_idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign frame_busy_c = bus.data_valid || (bin_cnt != '0) || s1_valid || s2_valid;

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            IDLE: if (bus.data_valid && (bin_cnt == '0)) state_d = SCAN;
            SCAN: if (cmp_last) state_d = DONE;
            DONE: begin
                load_c  = 1'b1;
                state_d = frame_busy_c ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result register: a new load always wins; losing an unaccepted result flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_valid_q <= 1'b0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            overrun_q    <= 1'b0;
        end else if (load_c) begin
            peak_valid_q <= 1'b1;
            peak_index_q <= fin_idx;
            peak_mag_q   <= fin_max;
            if (peak_valid_q && !bus.peak_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (peak_valid_q && bus.peak_ready) begin
            peak_valid_q <= 1'b0;
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_index = peak_index_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.overrun    = overrun_q;

endmodule
